// File: rtl/div_seq_ctrl.sv
// -----------------------------------------------------------------------------
// div_seq_ctrl
//
// Purpose:
//   Control FSM for a restoring iterative divider. The datapath outside this
//   block holds three loadable left-shift registers (A = dividend/quotient,
//   R = remainder, B = divisor) and a comparator/subtractor giving ge = (R >= B)
//   and R-B. This block issues every load/shift/enable strobe, counts the N
//   iterations, runs the start/done handshake and flags divide-by-zero.
//
// Handshake:
//   start is a request that is only looked at in IDLE; it is accepted on the
//   clock edge where the FSM sits in IDLE with start=1 and abort=0. There is
//   no back-pressure and no queueing: requests while busy or in DONE are
//   dropped. done is a single-cycle pulse that marks A/R as valid (or, when
//   div_by_zero is set, marks the rejected request as finished).
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   start        in   request a division (sampled in IDLE only)
//   abort        in   synchronous cancel, back to IDLE from any state
//   b_zero       in   divisor data input is zero
//   ge           in   comparator result R >= B
//   a_sL/a_E/a_w out  A load-select, enable, shift-in (quotient bit)
//   r_sL/r_E     out  R load-select, enable (shift-in is A[N-1] in datapath)
//   r_sel        out  R load data: 0 = zero, 1 = R-B
//   b_E          out  B load enable
//   busy         out  high in LOAD/SHIFT/SUB
//   done         out  one-cycle completion pulse
//   div_by_zero  out  sticky error flag, cleared by the next accepted start
//   o_dbg_state  out  current FSM state encoding
// -----------------------------------------------------------------------------
module div_seq_ctrl #(
  parameter int N     = 6,
  parameter int CNT_W = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       b_zero,
  input  logic       ge,
  output logic       a_sL,
  output logic       a_E,
  output logic       a_w,
  output logic       r_sL,
  output logic       r_E,
  output logic       r_sel,
  output logic       b_E,
  output logic       busy,
  output logic       done,
  output logic       div_by_zero,
  output logic [2:0] o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_SUB   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   w_count_nxt;
  logic               r_dz;
  logic               w_dz_nxt;

  // State, iteration counter and sticky error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_dz    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_dz    <= w_dz_nxt;
    end
  end

  // Next-state logic. abort overrides every transition, including start.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_dz_nxt    = r_dz;

    if (abort) begin
      w_state_nxt = S_IDLE;
      w_count_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (b_zero) begin
              // Rejected request: flag it and finish without touching A/R/B.
              w_dz_nxt    = 1'b1;
              w_state_nxt = S_DONE;
            end else begin
              w_dz_nxt    = 1'b0;
              w_state_nxt = S_LOAD;
            end
          end
        end
        S_LOAD: begin
          w_count_nxt = '0;
          w_state_nxt = S_SHIFT;
        end
        S_SHIFT: begin
          w_state_nxt = S_SUB;
        end
        S_SUB: begin
          if (r_count == LAST_ITER) begin
            w_state_nxt = S_DONE;
          end else begin
            w_count_nxt = r_count + CNT_W'(1);
            w_state_nxt = S_SHIFT;
          end
        end
        S_DONE: begin
          w_state_nxt = S_IDLE;
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_count_nxt = '0;
        end
      endcase
    end
  end

  // Strobes are a function of state only, except ge in SUB.
  always_comb begin
    a_sL  = 1'b0;
    a_E   = 1'b0;
    a_w   = 1'b0;
    r_sL  = 1'b0;
    r_E   = 1'b0;
    r_sel = 1'b0;
    b_E   = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;

    case (r_state)
      S_LOAD: begin
        a_sL = 1'b1;
        a_E  = 1'b1;
        b_E  = 1'b1;
        r_sL = 1'b1;
        r_E  = 1'b1;
        busy = 1'b1;
      end
      S_SHIFT: begin
        // R takes in A[N-1]; A is held so its MSB stays stable for SUB.
        r_E  = 1'b1;
        busy = 1'b1;
      end
      S_SUB: begin
        // Quotient bit enters A; R is replaced by R-B only when it fits.
        a_E   = 1'b1;
        a_w   = ge;
        r_E   = ge;
        r_sL  = 1'b1;
        r_sel = 1'b1;
        busy  = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign div_by_zero = r_dz;
  assign o_dbg_state = r_state;

endmodule
